sa_mode_switch: RTL and testbench



---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_mode_switch_if.sv | 42 ++++
 rtl/sa_out_reg.sv | 40 ++++
 rtl/sa_mode_switch.sv | 145 ++++++++++++++
 tb/tb_sa_mode_switch.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand mode switch.
//   - Mode encodings for the four standard operand streams.
//   - Mode-switch FSM state type.
//   - Default lane width and array dimension.
package sa_pkg;

  localparam int MODE_INF = 0;  // inference
  localparam int MODE_FW  = 1;  // forward pass
  localparam int MODE_BW  = 2;  // backward pass
  localparam int MODE_WU  = 3;  // weight update

  localparam int SA_DATA_WIDTH = 32;
  localparam int SA_SYS_DIM    = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } sa_state_e;

endpackage

// File: rtl/sa_mode_switch_if.sv
// Bundle of all stream, output and mode-control signals of sa_mode_switch.
//   master : the environment (stream producers, PE array, controller)
//   slave  : the mode switch itself
// Signals:
//   in_data/in_valid/in_ready      per-mode input streams (flattened data)
//   out_data/out_valid/out_ready   registered stream to the PE array
//   out_mode                       mode tag of the beat in out_data
//   mode_req/_valid/_ready         mode-change request handshake
//   mode_done/mode_err             completion / illegal-request pulses
//   cur_mode/busy                  status
interface sa_mode_switch_if #(
  parameter int NUM_MODES = 4,
  parameter int BUS_W     = 512,
  parameter int SEL_W     = $clog2(NUM_MODES)
);
  logic [NUM_MODES*BUS_W-1:0] in_data;
  logic [NUM_MODES-1:0]       in_valid;
  logic [NUM_MODES-1:0]       in_ready;
  logic [BUS_W-1:0]           out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [SEL_W-1:0]           out_mode;
  logic [SEL_W-1:0]           mode_req;
  logic                       mode_req_valid;
  logic                       mode_req_ready;
  logic                       mode_done;
  logic                       mode_err;
  logic [SEL_W-1:0]           cur_mode;
  logic                       busy;

  modport master (
    output in_data, in_valid, out_ready, mode_req, mode_req_valid,
    input  in_ready, out_data, out_valid, out_mode, mode_req_ready,
           mode_done, mode_err, cur_mode, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready, mode_req, mode_req_valid,
    output in_ready, out_data, out_valid, out_mode, mode_req_ready,
           mode_done, mode_err, cur_mode, busy
  );
endinterface

// File: rtl/sa_out_reg.sv
// Single-entry valid/ready pipeline register.
// Accepts a new payload whenever it is empty or its content leaves in the
// same cycle, so it sustains one beat per cycle with one cycle of latency.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_data   upstream payload offer
//   in_ready           register can take a payload this cycle
//   out_valid/out_data registered payload
//   out_ready          downstream accepts the payload
module sa_out_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sa_mode_switch.sv
// Registered operand mode switch for the systolic array.
// Forwards the stream of the active mode to the PE array through one
// valid/ready output register. A mode change stops intake, waits until the
// output register is empty and has stayed empty for DRAIN_CYCLES cycles, then
// switches in one SWITCH cycle, so beats of different modes never mix.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  sa_mode_switch_if.slave (streams, output, mode control, status)
module sa_mode_switch
  import sa_pkg::*;
#(
  parameter int dataWidth    = SA_DATA_WIDTH,
  parameter int SysDimension = SA_SYS_DIM,
  parameter int NUM_MODES    = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter int RESET_MODE   = MODE_INF
) (
  input logic             clk,
  input logic             rst,
  sa_mode_switch_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_MODES);
  localparam int BUS_W = dataWidth * SysDimension;
  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [SEL_W-1:0] RST_MODE = SEL_W'(RESET_MODE);
  localparam logic [SEL_W:0]   NMODES   = (SEL_W + 1)'(NUM_MODES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_CYCLES);

  sa_state_e        state, state_nxt;
  logic [SEL_W-1:0] cur_mode, cur_mode_nxt;
  logic [SEL_W-1:0] target, target_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             mode_done_nxt, mode_err_nxt;
  logic             mode_done_q, mode_err_q;

  logic             run;
  logic             req_illegal;
  logic             beat_valid;
  logic             reg_ready;
  logic [BUS_W-1:0] beat_data;

  assign run = (state == RUN);

  // A power-of-two mode count leaves no unrepresentable request code.
  if ((1 << SEL_W) == NUM_MODES) begin : g_no_illegal
    assign req_illegal = 1'b0;
  end else begin : g_illegal
    assign req_illegal = ({1'b0, bus.mode_req} >= NMODES);
  end

  // Stream select: only the active mode is ever offered to the register.
  assign beat_data  = bus.in_data[cur_mode*BUS_W +: BUS_W];
  assign beat_valid = run && !rst && bus.in_valid[cur_mode];

  always_comb begin
    bus.in_ready = '0;
    if (run && !rst) bus.in_ready[cur_mode] = reg_ready;
  end

  sa_out_reg #(
    .W       (BUS_W + SEL_W),
    .RST_VAL ({RST_MODE, {BUS_W{1'b0}}})
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (beat_valid),
    .in_data  ({cur_mode, beat_data}),
    .in_ready (reg_ready),
    .out_valid(bus.out_valid),
    .out_data ({bus.out_mode, bus.out_data}),
    .out_ready(bus.out_ready)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    cur_mode_nxt  = cur_mode;
    target_nxt    = target;
    drain_cnt_nxt = drain_cnt;
    mode_done_nxt = 1'b0;
    mode_err_nxt  = 1'b0;
    unique case (state)
      RUN: begin
        drain_cnt_nxt = '0;
        if (bus.mode_req_valid) begin
          if (req_illegal) begin
            mode_err_nxt = 1'b1;
          end else if (bus.mode_req == cur_mode) begin
            mode_done_nxt = 1'b1;
          end else begin
            target_nxt = bus.mode_req;
            state_nxt  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Count only consecutive empty cycles; a beat still in the output
        // restarts the quiet period. Equality exits, so it never wraps.
        if (bus.out_valid) begin
          drain_cnt_nxt = '0;
        end else if (drain_cnt == CNT_MAX) begin
          state_nxt = SWITCH;
        end else begin
          drain_cnt_nxt = drain_cnt + CNT_W'(1);
        end
      end
      SWITCH: begin
        cur_mode_nxt  = target;
        mode_done_nxt = 1'b1;
        drain_cnt_nxt = '0;
        state_nxt     = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cur_mode    <= RST_MODE;
      target      <= RST_MODE;
      drain_cnt   <= '0;
      mode_done_q <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_mode    <= cur_mode_nxt;
      target      <= target_nxt;
      drain_cnt   <= drain_cnt_nxt;
      mode_done_q <= mode_done_nxt;
      mode_err_q  <= mode_err_nxt;
    end
  end

  assign bus.mode_req_ready = run;
  assign bus.mode_done      = mode_done_q;
  assign bus.mode_err       = mode_err_q;
  assign bus.cur_mode       = cur_mode;
  assign bus.busy           = !run;

endmodule

// File: tb/tb_sa_mode_switch.sv
// Self-checking bench for sa_mode_switch: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_sa_mode_switch;

  localparam int NM = 5;  // five modes so that request codes 5..7 are illegal
  localparam int DW = 8;
  localparam int SD = 4;
  localparam int BW = DW * SD;
  localparam int SW = $clog2(NM);
  localparam int DC = 4;

  typedef struct {
    logic [BW-1:0] data;
    int            mode;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_mode_switch_if #(.NUM_MODES(NM), .BUS_W(BW)) bus ();

  sa_mode_switch #(
    .dataWidth   (DW),
    .SysDimension(SD),
    .NUM_MODES   (NM),
    .DRAIN_CYCLES(DC),
    .RESET_MODE  (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: active mode, pending target, empty-cycle count, the
  // output register as a queue of at most one beat, and expected pulses.
  int    m_cur, m_target, m_idle;
  bit    m_pend, m_sw, m_done, m_err;
  beat_t m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_target = 0; m_idle = 0;
    m_pend = 0; m_sw = 0; m_done = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit    was_full, rdy, n_done, n_err;
    int    req;
    beat_t b;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() != 0);
    rdy      = !m_pend && !m_sw && (!was_full || bus.out_ready);
    n_done   = 0;
    n_err    = 0;
    if (was_full && bus.out_ready) void'(m_q.pop_front());
    if (rdy && bus.in_valid[m_cur]) begin
      b.data = bus.in_data[m_cur*BW +: BW];
      b.mode = m_cur;
      m_q.push_back(b);
    end
    if (m_sw) begin
      m_cur  = m_target;
      m_sw   = 0;
      n_done = 1;
    end else if (m_pend) begin
      if (was_full) m_idle = 0;
      else if (m_idle == DC) begin m_pend = 0; m_sw = 1; end
      else m_idle++;
    end else if (bus.mode_req_valid) begin
      req = int'(bus.mode_req);
      if (req >= NM) n_err = 1;
      else if (req == m_cur) n_done = 1;
      else begin m_pend = 1; m_target = req; m_idle = 0; end
    end
    m_done = n_done;
    m_err  = n_err;
  endtask

  // Compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    logic [NM-1:0] exp_ir;
    bit            rdy;
    @(negedge clk);
    rdy    = !rst && !m_pend && !m_sw && (m_q.size() == 0 || bus.out_ready);
    exp_ir = '0;
    if (rdy) exp_ir[m_cur] = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    check("mode_req_ready", 64'(bus.mode_req_ready), 64'(!m_pend && !m_sw));
    check("busy", 64'(bus.busy), 64'(m_pend || m_sw));
    check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    check("cur_mode", 64'(bus.cur_mode), 64'(m_cur));
    check("mode_done", 64'(bus.mode_done), 64'(m_done));
    check("mode_err", 64'(bus.mode_err), 64'(m_err));
    if (m_q.size() != 0) begin
      check("out_data", 64'(bus.out_data), 64'(m_q[0].data));
      check("out_mode", 64'(bus.out_mode), 64'(m_q[0].mode));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [NM-1:0] v, input logic rdy, input logic rv, input int req);
    bus.in_valid       = v;
    bus.out_ready      = rdy;
    bus.mode_req_valid = rv;
    bus.mode_req       = SW'(req);
    for (int m = 0; m < NM; m++) bus.in_data[m*BW +: BW] = $urandom();
    step();
  endtask

  initial begin
    bus.in_data        = '0;
    bus.in_valid       = '0;
    bus.out_ready      = 1'b0;
    bus.mode_req       = '0;
    bus.mode_req_valid = 1'b0;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held: in_ready must stay low even with every stream valid.
    repeat (2) drive('1, 1'b1, 1'b0, 0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_mode", 64'(bus.out_mode), 64'd0);
    rst = 1'b0;

    // Eight beats on mode 0, other streams valid but ignored.
    repeat (8) drive('1, 1'b1, 1'b0, 0);
    drive('0, 1'b1, 1'b0, 0);

    // Back-pressure for five cycles mid-stream.
    repeat (2) drive(5'b00001, 1'b1, 1'b0, 0);
    repeat (5) drive(5'b00001, 1'b0, 1'b0, 0);
    repeat (3) drive(5'b00001, 1'b1, 1'b0, 0);

    // Request mode 2 while a beat is held for three cycles, then drain.
    drive(5'b00001, 1'b1, 1'b0, 0);
    drive(5'b00000, 1'b0, 1'b1, 2);
    repeat (2) drive(5'b00100, 1'b0, 1'b0, 0);
    repeat (12) drive(5'b00100, 1'b1, 1'b0, 0);

    // Same-mode request, then an illegal request.
    drive(5'b00000, 1'b1, 1'b1, 2);
    repeat (2) drive(5'b00000, 1'b1, 1'b0, 0);
    drive(5'b00000, 1'b1, 1'b1, 5);
    repeat (2) drive(5'b00000, 1'b1, 1'b0, 0);

    // Move to mode 1, then accept a mode-1 beat together with a mode-3 request.
    drive(5'b00000, 1'b1, 1'b1, 1);
    repeat (10) drive(5'b00000, 1'b1, 1'b0, 0);
    drive(5'b00010, 1'b1, 1'b1, 3);
    repeat (12) drive('1, 1'b1, 1'b0, 0);

    // Reset in the middle of a drain abandons the switch.
    drive(5'b01000, 1'b1, 1'b1, 0);
    repeat (2) drive('1, 1'b1, 1'b0, 0);
    rst = 1'b1;
    drive('1, 1'b1, 1'b0, 0);
    rst = 1'b0;
    repeat (8) drive('1, 1'b1, 1'b0, 0);

    // Randomized traffic, requests (including illegal codes) and rare resets.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(NM'($urandom()), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0), int'($urandom_range(0, 7)));
    end
    rst = 1'b0;
    repeat (4) drive('0, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
